// File: rtl/agusec_fault_stage_pkg.sv
// Shared definitions for the AGU security fault stage: fat-pointer field
// accessors, the illegal carry-class code and the tag width shared with the LSQ.
package agusec_fault_stage_pkg;

    localparam int         IIW_DEF      = 10;
    localparam logic [1:0] CSEL_ILLEGAL = 2'd3;

    // Fat pointer layout: exponent, upper bound bits, lower bound bits, on-low flag.
    function automatic logic [5:0] ptr_exp(input logic [63:0] p);
        return p[63:58];
    endfunction

    function automatic logic [7:0] ptr_hi(input logic [63:0] p);
        return p[57:50];
    endfunction

    function automatic logic [7:0] ptr_low(input logic [63:0] p);
        return p[49:42];
    endfunction

    function automatic logic ptr_on_low(input logic [63:0] p);
        return p[41];
    endfunction

endpackage

// File: rtl/agusec_fault_stage_ack_sel.sv
// Selects the upper-check ack for the carry class and offset sign, then
// combines it with the range check into a single fault verdict.
module agusec_ack_sel
    import agusec_fault_stage_pkg::*;
#(
    parameter int CHECK_EN = 1
) (
    input  logic       i_secq,
    input  logic [2:0] i_pos_ack,
    input  logic [2:0] i_neg_ack,
    input  logic [1:0] i_csel,
    input  logic       i_neg,
    output logic       o_ack,
    output logic       o_fault
);

    always_comb begin
        o_ack = 1'b0;
        if (i_csel != CSEL_ILLEGAL) begin
            o_ack = i_neg ? i_neg_ack[i_csel] : i_pos_ack[i_csel];
        end
    end

    assign o_fault = (CHECK_EN != 0) && !(i_secq && o_ack);

endmodule

// File: rtl/agusec_fault_stage.sv
// Two-stage register of the AGU security checks: S1 captures raw results,
// S2 holds the verdict, plus a sticky first-fault record and a fault counter.
module agusec_fault_stage
    import agusec_fault_stage_pkg::*;
#(
    parameter int IIW      = IIW_DEF,
    parameter int CNTW     = 8,
    parameter int CHECK_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_en,
    input  logic [63:0]     in_ptr,
    input  logic [43:0]     in_addr,
    input  logic [IIW-1:0]  in_ii,
    input  logic            in_secq,
    input  logic [2:0]      in_pos_ack,
    input  logic [2:0]      in_neg_ack,
    input  logic [1:0]      in_csel,
    input  logic            in_neg,
    output logic            out_en,
    output logic            out_fault,
    output logic [IIW-1:0]  out_ii,
    output logic [43:0]     out_addr,
    output logic            cap_valid,
    output logic [IIW-1:0]  cap_ii,
    output logic [43:0]     cap_addr,
    output logic [63:0]     cap_ptr,
    input  logic            cap_clr,
    output logic [CNTW-1:0] fault_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic            r_v1;
    logic [63:0]     r_ptr1;
    logic [43:0]     r_addr1;
    logic [IIW-1:0]  r_ii1;
    logic            r_secq1;
    logic [2:0]      r_pos_ack1;
    logic [2:0]      r_neg_ack1;
    logic [1:0]      r_csel1;
    logic            r_neg1;

    logic            r_out_en;
    logic            r_out_fault;
    logic [IIW-1:0]  r_out_ii;
    logic [43:0]     r_out_addr;

    logic            r_cap_valid;
    logic [IIW-1:0]  r_cap_ii;
    logic [43:0]     r_cap_addr;
    logic [63:0]     r_cap_ptr;
    logic [CNTW-1:0] r_fault_cnt;

    logic            w_ack;
    logic            w_fault;
    logic            w_fault_load;

    agusec_ack_sel #(
        .CHECK_EN (CHECK_EN)
    ) u_ack_sel (
        .i_secq    (r_secq1),
        .i_pos_ack (r_pos_ack1),
        .i_neg_ack (r_neg_ack1),
        .i_csel    (r_csel1),
        .i_neg     (r_neg1),
        .o_ack     (w_ack),
        .o_fault   (w_fault)
    );

    // A faulting entry only counts when S2 actually takes it this edge.
    assign w_fault_load = r_v1 && w_fault && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_ptr1     <= '0;
            r_addr1    <= '0;
            r_ii1      <= '0;
            r_secq1    <= 1'b0;
            r_pos_ack1 <= '0;
            r_neg_ack1 <= '0;
            r_csel1    <= '0;
            r_neg1     <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
        end else if (!stall) begin
            r_v1       <= in_en;
            r_ptr1     <= in_ptr;
            r_addr1    <= in_addr;
            r_ii1      <= in_ii;
            r_secq1    <= in_secq;
            r_pos_ack1 <= in_pos_ack;
            r_neg_ack1 <= in_neg_ack;
            r_csel1    <= in_csel;
            r_neg1     <= in_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en    <= 1'b0;
            r_out_fault <= 1'b0;
            r_out_ii    <= '0;
            r_out_addr  <= '0;
        end else if (flush) begin
            r_out_en    <= 1'b0;
            r_out_fault <= 1'b0;
        end else if (!stall) begin
            r_out_en    <= r_v1;
            r_out_fault <= r_v1 && w_fault;
            r_out_ii    <= r_ii1;
            r_out_addr  <= r_addr1;
        end
    end

    // cap_clr is applied before the capture test, so a fault on the same edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
            r_cap_ii    <= '0;
            r_cap_addr  <= '0;
            r_cap_ptr   <= '0;
        end else if (w_fault_load && (!r_cap_valid || cap_clr)) begin
            r_cap_valid <= 1'b1;
            r_cap_ii    <= r_ii1;
            r_cap_addr  <= r_addr1;
            r_cap_ptr   <= r_ptr1;
        end else if (cap_clr) begin
            r_cap_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_cnt <= '0;
        end else if (w_fault_load && (r_fault_cnt != CNT_MAX)) begin
            r_fault_cnt <= r_fault_cnt + CNTW'(1);
        end
    end

    assign out_en    = r_out_en;
    assign out_fault = r_out_fault;
    assign out_ii    = r_out_ii;
    assign out_addr  = r_out_addr;
    assign cap_valid = r_cap_valid;
    assign cap_ii    = r_cap_ii;
    assign cap_addr  = r_cap_addr;
    assign cap_ptr   = r_cap_ptr;
    assign fault_cnt = r_fault_cnt;

endmodule
